// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - control sequencer: fetch/latch/decode/execute T-states with memory wait states
// Outputs are decoded combinationally from state, captured op, flags and the wait counter.
module ctrl_seq #(
  parameter int MEM_WAIT = 0,
  parameter int ONEHOT_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [ONEHOT_W-1:0] op,
  input  logic                zf,
  input  logic                bf,
  output logic                iir,
  output logic                eir,
  output logic                epc,
  output logic                ipc,
  output logic                lpc,
  output logic                mar_ld,
  output logic                esp,
  output logic                sp_inc,
  output logic                sp_dec,
  output logic                mrd,
  output logic                mwr,
  output logic                acc_ld,
  output logic [1:0]          acc_src,
  output logic                acc_oe,
  output logic                b_ld,
  output logic [2:0]          alu_op,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_EX1, S_EX2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  localparam int OP_NOP  = 0;
  localparam int OP_LD   = 1;
  localparam int OP_LN   = 2;
  localparam int OP_CP   = 3;
  localparam int OP_ST   = 4;
  localparam int OP_SHL  = 5;
  localparam int OP_ADD  = 6;
  localparam int OP_SUB  = 7;
  localparam int OP_JZ   = 8;
  localparam int OP_JB   = 9;
  localparam int OP_JMP  = 10;
  localparam int OP_XOR  = 11;
  localparam int OP_OR   = 12;
  localparam int OP_AND  = 13;
  localparam int OP_SHR  = 14;
  localparam int OP_NOT  = 15;
  localparam int OP_PUSH = 16;
  localparam int OP_POP  = 17;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_wait;
  logic [3:0]            w_wait_next;
  logic [ONEHOT_W-1:0]   r_op;
  logic                  w_onehot;
  logic                  w_last;
  logic                  w_end;

  assign w_onehot = (op != '0) &&
                    ((op & (op - {{(ONEHOT_W-1){1'b0}}, 1'b1})) == '0);
  assign w_last   = (r_wait == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (r_state == S_DECODE) r_op <= op;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_next = r_wait;
    w_end       = 1'b0;
    iir = 1'b0; eir = 1'b0; epc = 1'b0; ipc = 1'b0; lpc = 1'b0;
    mar_ld = 1'b0; esp = 1'b0; sp_inc = 1'b0; sp_dec = 1'b0;
    mrd = 1'b0; mwr = 1'b0; acc_ld = 1'b0; acc_src = 2'd0;
    acc_oe = 1'b0; b_ld = 1'b0; alu_op = 3'd0; done = 1'b0; illegal = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next      = S_FETCH;
          w_wait_next = WAIT_INIT;
        end
      end
      S_FETCH: begin
        epc = 1'b1;
        mrd = 1'b1;
        if (w_last) w_next = S_LATCH;
        else        w_wait_next = r_wait - 4'd1;
      end
      S_LATCH: begin
        iir    = 1'b1;
        ipc    = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        // Live op is used here; r_op only becomes valid from EX1 onward.
        if (!w_onehot) begin
          illegal = 1'b1;
          done    = 1'b1;
          w_end   = 1'b1;
        end else if (op[OP_NOP]) begin
          done  = 1'b1;
          w_end = 1'b1;
        end else begin
          w_next = S_EX1;
          if (op[OP_POP]) w_wait_next = WAIT_INIT;
        end
      end
      S_EX1: begin
        if (r_op[OP_LD] || r_op[OP_ST]) begin
          eir    = 1'b1;
          mar_ld = 1'b1;
          w_next = S_EX2;
          if (r_op[OP_LD]) w_wait_next = WAIT_INIT;
        end else if (r_op[OP_LN]) begin
          eir = 1'b1; acc_ld = 1'b1; acc_src = 2'd1; done = 1'b1; w_end = 1'b1;
        end else if (r_op[OP_CP]) begin
          b_ld = 1'b1; done = 1'b1; w_end = 1'b1;
        end else if (r_op[OP_JMP] || (r_op[OP_JZ] && zf) || (r_op[OP_JB] && bf)) begin
          eir = 1'b1; lpc = 1'b1; done = 1'b1; w_end = 1'b1;
        end else if (r_op[OP_PUSH]) begin
          sp_dec = 1'b1;
          w_next = S_EX2;
        end else if (r_op[OP_POP]) begin
          esp     = 1'b1;
          mrd     = 1'b1;
          acc_src = 2'd2;
          if (w_last) begin
            acc_ld = 1'b1;
            w_next = S_EX2;
          end else begin
            w_wait_next = r_wait - 4'd1;
          end
        end else begin
          // ALU group and untaken branches finish here.
          done  = 1'b1;
          w_end = 1'b1;
          if (r_op[OP_SHL] || r_op[OP_ADD] || r_op[OP_SUB] || r_op[OP_XOR] ||
              r_op[OP_OR]  || r_op[OP_AND] || r_op[OP_SHR] || r_op[OP_NOT]) begin
            acc_ld = 1'b1;
            if      (r_op[OP_SUB]) alu_op = 3'd1;
            else if (r_op[OP_SHL]) alu_op = 3'd2;
            else if (r_op[OP_SHR]) alu_op = 3'd3;
            else if (r_op[OP_XOR]) alu_op = 3'd4;
            else if (r_op[OP_OR])  alu_op = 3'd5;
            else if (r_op[OP_AND]) alu_op = 3'd6;
            else if (r_op[OP_NOT]) alu_op = 3'd7;
            else                   alu_op = 3'd0;
          end
        end
      end
      S_EX2: begin
        if (r_op[OP_LD]) begin
          mrd     = 1'b1;
          acc_src = 2'd2;
          if (w_last) begin
            acc_ld = 1'b1; done = 1'b1; w_end = 1'b1;
          end else begin
            w_wait_next = r_wait - 4'd1;
          end
        end else if (r_op[OP_ST]) begin
          acc_oe = 1'b1; mwr = 1'b1; done = 1'b1; w_end = 1'b1;
        end else if (r_op[OP_PUSH]) begin
          esp = 1'b1; acc_oe = 1'b1; mwr = 1'b1; done = 1'b1; w_end = 1'b1;
        end else if (r_op[OP_POP]) begin
          sp_inc = 1'b1; done = 1'b1; w_end = 1'b1;
        end else begin
          w_end = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase

    if (w_end) begin
      if (run) begin
        w_next      = S_FETCH;
        w_wait_next = WAIT_INIT;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard bench for ctrl_seq at MEM_WAIT 0 and 2
module tb_ctrl_seq;

  localparam logic [20:0] IIR  = 21'd1 << 20;
  localparam logic [20:0] EIR  = 21'd1 << 19;
  localparam logic [20:0] EPC  = 21'd1 << 18;
  localparam logic [20:0] IPC  = 21'd1 << 17;
  localparam logic [20:0] LPC  = 21'd1 << 16;
  localparam logic [20:0] MAR  = 21'd1 << 15;
  localparam logic [20:0] ESP  = 21'd1 << 14;
  localparam logic [20:0] SPI  = 21'd1 << 13;
  localparam logic [20:0] SPD  = 21'd1 << 12;
  localparam logic [20:0] MRD  = 21'd1 << 11;
  localparam logic [20:0] MWR  = 21'd1 << 10;
  localparam logic [20:0] ACL  = 21'd1 << 9;
  localparam logic [20:0] SRC1 = 21'd1 << 7;
  localparam logic [20:0] SRC2 = 21'd2 << 7;
  localparam logic [20:0] AOE  = 21'd1 << 6;
  localparam logic [20:0] BLD  = 21'd1 << 5;
  localparam logic [20:0] DONE = 21'd1 << 1;
  localparam logic [20:0] ILL  = 21'd1;
  localparam logic [20:0] F    = EPC | MRD;
  localparam logic [20:0] L    = IIR | IPC;
  localparam logic [20:0] Z    = 21'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        run0, run1, zf, bf;
  logic [17:0] op0, op1;

  logic iir0, eir0, epc0, ipc0, lpc0, mar0, esp0, spi0, spd0, mrd0, mwr0, acl0, aoe0, bld0, done0, ill0;
  logic iir1, eir1, epc1, ipc1, lpc1, mar1, esp1, spi1, spd1, mrd1, mwr1, acl1, aoe1, bld1, done1, ill1;
  logic [1:0] src0, src1;
  logic [2:0] alu0, alu1;
  logic [20:0] w_o0, w_o1;

  logic [20:0] q0[$];
  logic [20:0] q1[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.MEM_WAIT(0), .ONEHOT_W(18)) u_dut0 (
    .clk(clk), .rst(rst), .run(run0), .op(op0), .zf(zf), .bf(bf),
    .iir(iir0), .eir(eir0), .epc(epc0), .ipc(ipc0), .lpc(lpc0), .mar_ld(mar0),
    .esp(esp0), .sp_inc(spi0), .sp_dec(spd0), .mrd(mrd0), .mwr(mwr0),
    .acc_ld(acl0), .acc_src(src0), .acc_oe(aoe0), .b_ld(bld0), .alu_op(alu0),
    .done(done0), .illegal(ill0)
  );

  ctrl_seq #(.MEM_WAIT(2), .ONEHOT_W(18)) u_dut1 (
    .clk(clk), .rst(rst), .run(run1), .op(op1), .zf(zf), .bf(bf),
    .iir(iir1), .eir(eir1), .epc(epc1), .ipc(ipc1), .lpc(lpc1), .mar_ld(mar1),
    .esp(esp1), .sp_inc(spi1), .sp_dec(spd1), .mrd(mrd1), .mwr(mwr1),
    .acc_ld(acl1), .acc_src(src1), .acc_oe(aoe1), .b_ld(bld1), .alu_op(alu1),
    .done(done1), .illegal(ill1)
  );

  assign w_o0 = {iir0, eir0, epc0, ipc0, lpc0, mar0, esp0, spi0, spd0, mrd0, mwr0,
                 acl0, src0, aoe0, bld0, alu0, done0, ill0};
  assign w_o1 = {iir1, eir1, epc1, ipc1, lpc1, mar1, esp1, spi1, spd1, mrd1, mwr1,
                 acl1, src1, aoe1, bld1, alu1, done1, ill1};

  always @(negedge clk) begin
    logic [20:0] exp_v;
    if (q0.size() > 0) begin
      exp_v = q0.pop_front();
      n_vec++;
      if (w_o0 !== exp_v) begin
        n_err++;
        $display("FAIL dut0_vec%0d t=%0t: got %h required %h", n_vec, $time, w_o0, exp_v);
      end
    end
    if (q1.size() > 0) begin
      exp_v = q1.pop_front();
      n_vec++;
      if (w_o1 !== exp_v) begin
        n_err++;
        $display("FAIL dut1_vec%0d t=%0t: got %h required %h", n_vec, $time, w_o1, exp_v);
      end
    end
  end

  task automatic p0(input logic [20:0] v);
    q0.push_back(v);
  endtask

  task automatic p1(input logic [20:0] v);
    q1.push_back(v);
  endtask

  task automatic drain;
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      $display("FAIL drain_timeout: %0d/%0d entries left, required 0", q0.size(), q1.size());
      $fatal(1);
    end
  endtask

  task automatic instr0(input logic [17:0] op, input logic [20:0] ex1, input logic [20:0] ex2, input bit two);
    op0 = op;
    p0(F); p0(L); p0(Z); p0(ex1);
    if (two) p0(ex2);
    drain();
  endtask

  initial begin
    rst = 1'b1; run0 = 1'b0; run1 = 1'b0; zf = 1'b0; bf = 1'b0;
    op0 = 18'd0; op1 = 18'd0;
    p0(Z); p0(Z); p1(Z);
    drain();
    rst = 1'b0;
    p0(Z); p1(Z);
    drain();

    // nop then nop interrupted by reset while in LATCH
    run0 = 1'b1; op0 = 18'h00001;
    p0(F); p0(L); p0(DONE);
    drain();
    p0(F);
    drain();
    @(posedge clk); #1;
    rst = 1'b1;
    p0(Z);
    drain();
    rst = 1'b0;

    instr0(18'd1 << 6,  ACL | DONE, Z, 1'b0);
    instr0(18'd1 << 15, ACL | (21'd7 << 2) | DONE, Z, 1'b0);
    instr0(18'd1 << 7,  ACL | (21'd1 << 2) | DONE, Z, 1'b0);
    instr0(18'd1 << 5,  ACL | (21'd2 << 2) | DONE, Z, 1'b0);
    zf = 1'b1;
    instr0(18'd1 << 8,  EIR | LPC | DONE, Z, 1'b0);
    zf = 1'b0;
    instr0(18'd1 << 8,  DONE, Z, 1'b0);
    bf = 1'b1;
    instr0(18'd1 << 9,  EIR | LPC | DONE, Z, 1'b0);
    bf = 1'b0;
    instr0(18'd1 << 9,  DONE, Z, 1'b0);
    instr0(18'd1 << 10, EIR | LPC | DONE, Z, 1'b0);
    instr0(18'd1 << 2,  EIR | ACL | SRC1 | DONE, Z, 1'b0);
    instr0(18'd1 << 3,  BLD | DONE, Z, 1'b0);
    instr0(18'd1 << 4,  EIR | MAR, AOE | MWR | DONE, 1'b1);
    instr0(18'd1 << 1,  EIR | MAR, MRD | ACL | SRC2 | DONE, 1'b1);
    instr0(18'd1 << 16, SPD, ESP | AOE | MWR | DONE, 1'b1);
    instr0(18'd1 << 17, ESP | MRD | ACL | SRC2, SPI | DONE, 1'b1);

    // illegal encodings; run drops mid-instruction so the sequencer parks in IDLE
    op0 = 18'h00003;
    p0(F); p0(L); p0(ILL | DONE); p0(Z); p0(Z);
    @(negedge clk); #1;
    run0 = 1'b0;
    drain();
    run0 = 1'b1; op0 = 18'h00000;
    p0(F); p0(L); p0(ILL | DONE); p0(Z);
    @(negedge clk); #1;
    run0 = 1'b0;
    drain();

    // MEM_WAIT = 2: ld then pop, run dropped during pop
    run1 = 1'b1; op1 = 18'd1 << 1;
    p1(F); p1(F); p1(F); p1(L); p1(Z); p1(EIR | MAR);
    p1(MRD | SRC2); p1(MRD | SRC2); p1(MRD | SRC2 | ACL | DONE);
    drain();
    op1 = 18'd1 << 17;
    p1(F); p1(F); p1(F); p1(L); p1(Z);
    p1(ESP | MRD | SRC2); p1(ESP | MRD | SRC2); p1(ESP | MRD | SRC2 | ACL);
    p1(SPI | DONE); p1(Z); p1(Z);
    @(negedge clk); #1;
    run1 = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
